cmu_multiphase: RTL and testbench

//   Parametrised clock-management unit: divides clk_i into a frame of NUM_PHASES
//   non-overlapping one-cycle phase enables with a programmable slot length.

---
 rtl/cmu_multiphase.sv | 165 ++++++++++++++++
 tb/tb_cmu_multiphase.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmu_multiphase.sv
// cmu_multiphase
//   Clock-management unit. Divides clk_i into frames of NUM_PHASES
//   non-overlapping one-cycle phase enables, each slot lasting P cycles.
//   A new slot length is held pending and takes effect only at a frame
//   boundary (FB), or at once while halted. Unmasked interrupts or step mode
//   halt the sequencer, but only at a frame boundary. Step mode then runs one
//   whole frame per step_i pulse. Completed frames are counted.
//
// Ports
//   clk_i          in   1           system clock
//   clear_i        in   1           synchronous active-high reset
//   period_i       in   PERIOD_W    requested slot length (values below 2 become 2)
//   period_load_i  in   1           capture period_i as the pending slot length
//   intr_i         in   NUM_INTR    interrupt requests (level)
//   intr_mask_i    in   NUM_INTR    1 = ignore the matching intr_i bit
//   step_mode_i    in   1           1 = halt and advance only on step_i
//   step_i         in   1           run exactly one frame while halted
//   phi_o          out  NUM_PHASES  one-hot-or-zero phase enables
//   halted_o       out  1           sequencer frozen in HALT
//   frame_cnt_o    out  CNT_W       completed frames, wraps
//   clk_o          out  1           clk_i forwarded
//   clear_o        out  1           clear_i forwarded
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | free-running; frames repeat
// DRAIN | halt requested; finish the current frame, then HALT
// HALT  | frozen at the frame start; no phase enables
// STEP  | run exactly one frame, then HALT (or RUN if nothing holds it)

module cmu_multiphase #(
    parameter int NUM_PHASES     = 2,
    parameter int PERIOD_W       = 4,
    parameter int DEFAULT_PERIOD = 2,
    parameter int NUM_INTR       = 2,
    parameter int CNT_W          = 16
) (
    input  logic                  clk_i,
    input  logic                  clear_i,
    input  logic [PERIOD_W-1:0]   period_i,
    input  logic                  period_load_i,
    input  logic [NUM_INTR-1:0]   intr_i,
    input  logic [NUM_INTR-1:0]   intr_mask_i,
    input  logic                  step_mode_i,
    input  logic                  step_i,
    output logic [NUM_PHASES-1:0] phi_o,
    output logic                  halted_o,
    output logic [CNT_W-1:0]      frame_cnt_o,
    output logic                  clk_o,
    output logic                  clear_o
);

    localparam int PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
    localparam logic [PH_W-1:0]     PH_LAST   = PH_W'(NUM_PHASES - 1);
    localparam logic [PERIOD_W-1:0] P_MIN     = PERIOD_W'(2);
    localparam logic [PERIOD_W-1:0] P_DEFAULT = PERIOD_W'(DEFAULT_PERIOD);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_HALT  = 2'd2,
        S_STEP  = 2'd3
    } state_t;

    state_t              state;
    logic [PERIOD_W-1:0] tick;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] pend_period;
    logic                pend_vld;
    logic [PH_W-1:0]     ph;
    logic [CNT_W-1:0]    frame_cnt;

    logic                advancing;
    logic                slot_end;
    logic                fb;
    logic                intr_act;
    logic [PERIOD_W-1:0] load_val;

    assign advancing = (state != S_HALT);
    assign slot_end  = (tick == period - PERIOD_W'(1));
    assign fb        = advancing && slot_end && (ph == PH_LAST);
    assign intr_act  = |(intr_i & ~intr_mask_i);
    assign load_val  = (period_i < P_MIN) ? P_MIN : period_i;

    // Decoded from registers only, so no pulse can appear in the cycle
    // after a clear edge.
    always_comb begin
        phi_o = '0;
        if (advancing && slot_end) begin
            phi_o[ph] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            state       <= S_RUN;
            tick        <= '0;
            ph          <= '0;
            period      <= P_DEFAULT;
            pend_period <= P_DEFAULT;
            pend_vld    <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (intr_act || step_mode_i) begin
                        state <= fb ? S_HALT : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (fb) begin
                        state <= S_HALT;
                    end
                end
                S_HALT: begin
                    if (!intr_act && !step_mode_i) begin
                        state <= S_RUN;
                    end else if (step_mode_i && step_i && !intr_act) begin
                        state <= S_STEP;
                    end
                end
                S_STEP: begin
                    if (fb) begin
                        state <= (!step_mode_i && !intr_act) ? S_RUN : S_HALT;
                    end
                end
                default: state <= S_RUN;
            endcase

            if (advancing) begin
                if (slot_end) begin
                    tick <= '0;
                    ph   <= (ph == PH_LAST) ? '0 : ph + PH_W'(1);
                end else begin
                    tick <= tick + PERIOD_W'(1);
                end
            end else begin
                tick <= '0;
                ph   <= '0;
            end

            if (fb) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end

            // Apply the previously pending length first. A load in the same
            // cycle then overwrites the pending slot, so it waits for the
            // next boundary.
            if (pend_vld && (fb || state == S_HALT)) begin
                period   <= pend_period;
                pend_vld <= 1'b0;
            end
            if (period_load_i) begin
                pend_period <= load_val;
                pend_vld    <= 1'b1;
            end
        end
    end

    assign halted_o    = (state == S_HALT);
    assign frame_cnt_o = frame_cnt;
    assign clk_o       = clk_i;
    assign clear_o     = clear_i;

endmodule

// File: tb/tb_cmu_multiphase.sv
module tb_cmu_multiphase;

    localparam int NPH  = 2;
    localparam int PW   = 4;
    localparam int DEFP = 2;
    localparam int NI   = 2;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          clear = 1'b1;
    logic [PW-1:0] period = '0;
    logic          period_load = 1'b0;
    logic [NI-1:0] intr = '0;
    logic [NI-1:0] mask = '0;
    logic          smode = 1'b0;
    logic          step = 1'b0;
    logic [NPH-1:0] phi;
    logic          halted;
    logic [CW-1:0] fc;
    logic          clk_o;
    logic          clear_o;

    int total = 0;
    int bad   = 0;

    // Reference model: position within the frame in cycles, plus run flags.
    int m_c, m_P, m_pend, m_fc;
    bit m_pend_vld, m_halted, m_stop, m_stepping;

    cmu_multiphase #(
        .NUM_PHASES(NPH), .PERIOD_W(PW), .DEFAULT_PERIOD(DEFP),
        .NUM_INTR(NI), .CNT_W(CW)
    ) dut (
        .clk_i(clk), .clear_i(clear), .period_i(period),
        .period_load_i(period_load), .intr_i(intr), .intr_mask_i(mask),
        .step_mode_i(smode), .step_i(step), .phi_o(phi), .halted_o(halted),
        .frame_cnt_o(fc), .clk_o(clk_o), .clear_o(clear_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit act;
        act = |(intr & ~mask);
        if (clear) begin
            m_c = 0; m_P = DEFP; m_pend_vld = 0; m_halted = 0;
            m_stop = 0; m_stepping = 0; m_fc = 0;
            return;
        end
        if (m_halted) begin
            if (m_pend_vld) begin
                m_P = m_pend;
                m_pend_vld = 0;
            end
            if (!act && !smode) begin
                m_halted = 0;
            end else if (smode && step && !act) begin
                m_halted = 0;
                m_stepping = 1;
            end
        end else begin
            if (!m_stepping && (act || smode)) m_stop = 1;
            if (m_c == NPH * m_P - 1) begin
                m_c = 0;
                m_fc = (m_fc + 1) % (1 << CW);
                if (m_pend_vld) begin
                    m_P = m_pend;
                    m_pend_vld = 0;
                end
                if (m_stepping) begin
                    m_halted = smode || act;
                    m_stepping = 0;
                end else if (m_stop) begin
                    m_halted = 1;
                    m_stop = 0;
                end
            end else begin
                m_c++;
            end
        end
        if (period_load) begin
            m_pend = (period < 2) ? 2 : int'(period);
            m_pend_vld = 1;
        end
    endtask

    function automatic logic [31:0] exp_phi();
        if (!m_halted && (m_c % m_P) == m_P - 1) return 32'(1) << (m_c / m_P);
        return 32'(0);
    endfunction

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("phi", 32'(phi), exp_phi());
        chk("halted", 32'(halted), 32'(m_halted));
        chk("frame_cnt", 32'(fc), 32'(m_fc));
    endtask

    task automatic wait_fb();
        logic [CW-1:0] f0;
        bit found;
        f0 = fc;
        found = 0;
        for (int i = 0; i < 64; i++) begin
            cyc();
            if (fc != f0) begin
                found = 1;
                break;
            end
        end
        chk("wait_fb_timeout", 32'(found), 32'(1));
    endtask

    task automatic measure(output int p0, output int p1, output int len);
        logic [CW-1:0] f0;
        f0 = fc;
        p0 = -1; p1 = -1; len = -1;
        for (int i = 1; i <= 64; i++) begin
            cyc();
            if (phi[0]) p0 = i;
            if (phi[1]) p1 = i;
            if (fc != f0) begin
                len = i;
                break;
            end
        end
    endtask

    initial begin
        logic [1:0] seq_phi [4];
        bit         seq_hlt [4];
        int p0, p1, len, hcnt, budget;
        logic [CW-1:0] fc0;
        bit found;

        seq_phi = '{2'b01, 2'b00, 2'b10, 2'b00};
        seq_hlt = '{1'b0, 1'b0, 1'b0, 1'b1};

        // Reset
        cyc();
        chk("rst_phi", 32'(phi), 32'(0));
        chk("rst_halted", 32'(halted), 32'(0));
        chk("rst_fc", 32'(fc), 32'(0));
        chk("clear_o", 32'(clear_o), 32'(1));
        chk("clk_o", 32'(clk_o), 32'(clk));
        clear = 1'b0;

        // Free run, P=2
        for (int i = 1; i <= 8; i++) begin
            cyc();
            chk("run_seq", 32'(phi), 32'(seq_phi[(i - 1) % 4]));
            if (i % 4 == 0) chk("run_fc", 32'(fc), 32'(i / 4));
        end

        // Period load mid-frame applies at the next boundary
        cyc();
        period = 4'd5;
        period_load = 1'b1;
        cyc();
        period_load = 1'b0;
        wait_fb();
        measure(p0, p1, len);
        chk("p5_phi0_pos", 32'(p0), 32'(4));
        chk("p5_phi1_pos", 32'(p1), 32'(9));
        chk("p5_frame_len", 32'(len), 32'(10));
        period = 4'd0;
        period_load = 1'b1;
        cyc();
        period_load = 1'b0;
        wait_fb();
        measure(p0, p1, len);
        chk("p0_phi0_pos", 32'(p0), 32'(1));
        chk("p0_phi1_pos", 32'(p1), 32'(3));
        chk("p0_frame_len", 32'(len), 32'(4));

        // Interrupt halts only at the frame boundary
        cyc();
        intr = 2'b01;
        cyc();
        cyc();
        chk("intr_phi1_issued", 32'(phi), 32'(2));
        chk("intr_not_yet_halted", 32'(halted), 32'(0));
        cyc();
        chk("intr_halted", 32'(halted), 32'(1));
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("intr_hold_phi", 32'(phi), 32'(0));
        end
        intr = 2'b00;
        cyc();
        chk("intr_release", 32'(halted), 32'(0));
        mask = 2'b01;
        intr = 2'b01;
        hcnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (halted) hcnt++;
        end
        chk("masked_no_halt", 32'(hcnt), 32'(0));
        intr = 2'b00;
        mask = 2'b00;

        // Single-frame stepping
        smode = 1'b1;
        found = 0;
        for (budget = 0; budget < 16; budget++) begin
            cyc();
            if (halted) begin
                found = 1;
                break;
            end
        end
        chk("step_mode_halt", 32'(found), 32'(1));
        cyc();
        cyc();
        chk("step_idle_halted", 32'(halted), 32'(1));
        fc0 = fc;
        step = 1'b1;
        cyc();
        step = 1'b0;
        chk("step_start_phi", 32'(phi), 32'(0));
        chk("step_start_halted", 32'(halted), 32'(0));
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("step_phi", 32'(phi), 32'(seq_phi[k]));
            chk("step_halted", 32'(halted), 32'(seq_hlt[k]));
        end
        chk("step_fc", 32'(fc), 32'(fc0 + 4'd1));

        // Clear in the middle of a stepped frame
        step = 1'b1;
        cyc();
        step = 1'b0;
        cyc();
        cyc();
        clear = 1'b1;
        cyc();
        chk("clr_phi", 32'(phi), 32'(0));
        chk("clr_fc", 32'(fc), 32'(0));
        chk("clr_halted", 32'(halted), 32'(0));
        clear = 1'b0;
        smode = 1'b0;
        cyc();
        chk("clr_restart_phi", 32'(phi), 32'(1));

        // Frame counter wrap
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            cyc();
            chk("wrap_seq", 32'(phi), 32'(seq_phi[(i - 1) % 4]));
            if (i % 4 == 0) chk("wrap_fc", 32'(fc), 32'((i / 4) % 16));
        end

        // Randomised traffic against the model
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(7) == 0) intr = 2'($urandom_range(3));
            if ($urandom_range(7) == 0) mask = 2'($urandom_range(3));
            if ($urandom_range(15) == 0) smode = ~smode;
            step = ($urandom_range(3) == 0);
            period_load = ($urandom_range(5) == 0);
            period = 4'($urandom_range(15));
            clear = ($urandom_range(199) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
